uart_boot_loader: RTL and testbench

//  Upstream boot stage for the SoC top: receives a framed memory image over UART (8N1), writes it

---
 rtl/uart_boot_loader.sv | 207 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: parses A5-framed WRITE/RUN commands, writes words through a req/gnt port,
// then raises fetch_en. Define UART_BOOT_CSUM_EN to expect a trailing XOR checksum on WRITE frames.
module uart_boot_loader #(
   parameter int CLKS_PER_BIT = 16,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  uart_rx,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_gnt,
   output logic                  fetch_en,
   output logic                  busy,
   output logic                  err_frame,
   output logic                  err_ovr,
   output logic                  err_cmd
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_HUNT, S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM, S_RUN} state_t;

   rx_state_t             r_rx_state, w_rx_next;
   logic                  r_rx_meta, r_rx_sync;
   logic [CW-1:0]         r_rx_cnt;
   logic [2:0]            r_rx_bit;
   logic [7:0]            r_rx_shift;
   logic                  w_half, w_full, w_byte_vld, w_byte_err;
   logic [7:0]            w_byte;

   state_t                r_state, w_next;
   logic [1:0]            r_bcnt;
   logic [23:0]           r_abuf, r_wbuf;
   logic [7:0]            r_len_lo;
   logic [15:0]           r_left;
   logic [ADDR_WIDTH-1:0] r_naddr, r_waddr;
   logic [31:0]           r_wdata;
   logic                  r_req, r_fetch, r_err_frame, r_err_ovr, r_err_cmd;
   logic [31:0]           w_abuf_nxt, w_word;
   logic [15:0]           w_len_nxt;
`ifdef UART_BOOT_CSUM_EN
   logic [7:0]            r_csum;
`endif

   assign w_half = (r_rx_cnt == CW'(CLKS_PER_BIT / 2 - 1));
   assign w_full = (r_rx_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_byte = r_rx_shift;

   always_comb begin
      w_rx_next  = r_rx_state;
      w_byte_vld = 1'b0;
      w_byte_err = 1'b0;
      case (r_rx_state)
         RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
         RX_START: if (w_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_full && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
         RX_STOP:  if (w_full) begin
            w_rx_next  = RX_IDLE;
            w_byte_vld = r_rx_sync;
            w_byte_err = !r_rx_sync;
         end
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_meta  <= uart_rx;
         r_rx_sync  <= r_rx_meta;
         r_rx_state <= w_rx_next;
         if (r_rx_state == RX_IDLE || (r_rx_state == RX_START && w_half) || w_full)
            r_rx_cnt <= '0;
         else
            r_rx_cnt <= r_rx_cnt + CW'(1);
         if (r_rx_state == RX_DATA && w_full) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
      end
   end

   assign w_abuf_nxt = {w_byte, r_abuf};
   assign w_word     = {w_byte, r_wbuf};
   assign w_len_nxt  = {w_byte, r_len_lo};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_HUNT: if (w_byte_vld && w_byte == 8'hA5) w_next = S_CMD;
         S_CMD:  if (w_byte_vld) begin
            if (w_byte == 8'h01)      w_next = S_ADDR;
            else if (w_byte == 8'h02) w_next = S_RUN;
            else                      w_next = S_HUNT;
         end
         S_ADDR: if (w_byte_vld && r_bcnt == 2'd3) w_next = S_LEN;
`ifdef UART_BOOT_CSUM_EN
         S_LEN:  if (w_byte_vld && r_bcnt == 2'd1) w_next = (w_len_nxt == '0) ? S_CSUM : S_DATA;
         S_DATA: if (r_left == '0) w_next = S_CSUM;
`else
         S_LEN:  if (w_byte_vld && r_bcnt == 2'd1) w_next = (w_len_nxt == '0) ? S_HUNT : S_DATA;
         S_DATA: if (r_left == '0 && (!r_req || mem_gnt)) w_next = S_HUNT;
`endif
         S_CSUM: if (w_byte_vld) w_next = S_HUNT;
         S_RUN:  w_next = S_RUN;
         default: w_next = S_HUNT;
      endcase
      if (w_byte_err && r_state != S_RUN) w_next = S_HUNT;
   end

   // r_naddr is the slot for the next assembled word; it advances only when a word is accepted,
   // so a pending write keeps its address even if a new frame loads a fresh base meanwhile.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_HUNT;
         r_bcnt      <= '0;
         r_abuf      <= '0;
         r_wbuf      <= '0;
         r_len_lo    <= '0;
         r_left      <= '0;
         r_naddr     <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_req       <= 1'b0;
         r_fetch     <= 1'b0;
         r_err_frame <= 1'b0;
         r_err_ovr   <= 1'b0;
         r_err_cmd   <= 1'b0;
`ifdef UART_BOOT_CSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (r_req && mem_gnt) r_req <= 1'b0;
         if (w_byte_err) r_err_frame <= 1'b1;
         if (w_byte_vld) begin
`ifdef UART_BOOT_CSUM_EN
            if (r_state inside {S_CMD, S_ADDR, S_LEN} || (r_state == S_DATA && r_left != '0))
               r_csum <= r_csum ^ w_byte;
`endif
            case (r_state)
               S_HUNT: if (w_byte == 8'hA5) begin
                  r_bcnt <= '0;
`ifdef UART_BOOT_CSUM_EN
                  r_csum <= '0;
`endif
               end
               S_CMD: begin
                  r_bcnt <= '0;
                  if (w_byte == 8'h02) r_fetch <= 1'b1;
                  else if (w_byte != 8'h01) r_err_cmd <= 1'b1;
               end
               S_ADDR: begin
                  r_abuf <= w_abuf_nxt[31:8];
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) r_naddr <= ADDR_WIDTH'(w_abuf_nxt & ~32'd3);
               end
               S_LEN: begin
                  r_len_lo <= w_byte;
                  r_bcnt   <= (r_bcnt == 2'd1) ? 2'd0 : r_bcnt + 2'd1;
                  if (r_bcnt == 2'd1) r_left <= w_len_nxt;
               end
               S_DATA: if (r_left != '0) begin
                  r_wbuf <= w_word[31:8];
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     r_left <= r_left - 16'd1;
                     if (r_req) begin
                        r_err_ovr <= 1'b1;
                     end else begin
                        r_req   <= 1'b1;
                        r_wdata <= w_word;
                        r_waddr <= r_naddr;
                        r_naddr <= r_naddr + ADDR_WIDTH'(4);
                     end
                  end
               end
`ifdef UART_BOOT_CSUM_EN
               S_CSUM: if (w_byte != r_csum) r_err_cmd <= 1'b1;
`endif
               default: ;
            endcase
         end
      end
   end

   assign mem_req   = r_req;
   assign mem_we    = r_req;
   assign mem_be    = {4{r_req}};
   assign mem_addr  = r_waddr;
   assign mem_wdata = r_wdata;
   assign fetch_en  = r_fetch;
   assign err_frame = r_err_frame;
   assign err_ovr   = r_err_ovr;
   assign err_cmd   = r_err_cmd;
   assign busy      = (r_state != S_HUNT && r_state != S_RUN) || r_req;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes are queued as frames are sent and
// popped on each req&gnt handshake.
module tb_uart_boot_loader;
   localparam int CPB = 16;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk, rst, uart_rx, mem_gnt;
   logic        mem_req, mem_we, fetch_en, busy, err_frame, err_ovr, err_cmd;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_unexp  = 0;
   int          n_req_cyc = 0;
   int          gnt_mode = 0;
   int          req_snap;
   wr_t         exp_q[$];
`ifdef UART_BOOT_CSUM_EN
   logic [7:0]  tb_csum;
`endif

   uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .uart_rx(uart_rx),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_gnt(mem_gnt), .fetch_en(fetch_en), .busy(busy),
      .err_frame(err_frame), .err_ovr(err_ovr), .err_cmd(err_cmd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Grant generator: 0 = tied high, 1 = grant after 5 cycles of req, 2 = held low.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      mem_gnt  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (gnt_mode)
            0: mem_gnt = 1'b1;
            1: begin
               if (mem_req) begin
                  wait_cnt++;
                  mem_gnt = (wait_cnt >= 5);
               end else begin
                  wait_cnt = 0;
                  mem_gnt  = 1'b0;
               end
            end
            default: begin
               wait_cnt = 0;
               mem_gnt  = 1'b0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && mem_req && mem_gnt) begin
         if (exp_q.size() == 0) n_unexp++;
         else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e.addr));
            chk("wr_data", 64'(mem_wdata), 64'(e.data));
            chk("wr_be", 64'(mem_be), 64'hF);
            chk("wr_we", 64'(mem_we), 64'h1);
         end
      end
      if (mem_req) n_req_cyc++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic bit_time(input logic v);
      uart_rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop);
      bit_time(1'b1);
   endtask

   task automatic put(input logic [7:0] b);
`ifdef UART_BOOT_CSUM_EN
      tb_csum ^= b;
`endif
      send_byte(b, 1'b1);
   endtask

   task automatic write_frame(input logic [31:0] addr, input logic [15:0] n, input logic [95:0] words);
      logic [31:0] w;
      send_byte(8'hA5, 1'b1);
`ifdef UART_BOOT_CSUM_EN
      tb_csum = '0;
`endif
      put(8'h01);
      for (int i = 0; i < 4; i++) put(addr[8*i +: 8]);
      put(n[7:0]);
      put(n[15:8]);
      for (int i = 0; i < int'(n); i++) begin
         w = words[32*i +: 32];
         for (int j = 0; j < 4; j++) put(w[8*j +: 8]);
      end
`ifdef UART_BOOT_CSUM_EN
      send_byte(tb_csum, 1'b1);
`endif
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 3000 && busy; i++) begin
         @(posedge clk);
         #1;
      end
      chk(tag, 64'(busy), 64'd0);
   endtask

   initial begin
      rst     = 1'b1;
      uart_rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_fetch", 64'(fetch_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_errs", 64'({err_frame, err_ovr, err_cmd}), 64'd0);
      chk("rst_be", 64'(mem_be), 64'd0);
      repeat (10) @(posedge clk);
      #1;

      gnt_mode = 0;
      push_exp(32'h0, 32'hDEADBEEF);
      write_frame(32'h0, 16'd1, {64'h0, 32'hDEADBEEF});
      wait_drain("t1_drain");
      wait_idle("t1_idle");
      chk("t1_errs", 64'({err_frame, err_ovr, err_cmd}), 64'd0);

      gnt_mode = 1;
      push_exp(32'h00100000, 32'h11223344);
      push_exp(32'h00100004, 32'h55667788);
      push_exp(32'h00100008, 32'h99AABBCC);
      write_frame(32'h00100000, 16'd3, {32'h99AABBCC, 32'h55667788, 32'h11223344});
      wait_drain("t2_drain");
      wait_idle("t2_idle");

      gnt_mode = 2;
      push_exp(32'h200, 32'hA1A2A3A4);
      write_frame(32'h200, 16'd2, {32'h0, 32'hB1B2B3B4, 32'hA1A2A3A4});
      repeat (4) @(posedge clk);
      #1;
      chk("t3_ovr", 64'(err_ovr), 64'd1);
      chk("t3_req_held", 64'(mem_req), 64'd1);
      chk("t3_addr_held", 64'(mem_addr), 64'h200);
      chk("t3_busy", 64'(busy), 64'd1);
      gnt_mode = 1;
      wait_drain("t3_drain");
      wait_idle("t3_idle");

      gnt_mode = 0;
      chk("t5_err_frame_pre", 64'(err_frame), 64'd0);
      send_byte(8'h55, 1'b0);
      repeat (12) bit_time(1'b1);
      chk("t5_err_frame", 64'(err_frame), 64'd1);
      push_exp(32'h40, 32'hCAFEF00D);
      write_frame(32'h40, 16'd1, {64'h0, 32'hCAFEF00D});
      wait_drain("t5_drain");
      wait_idle("t5_idle");

      req_snap = n_req_cyc;
      write_frame(32'h300, 16'd0, 96'h0);
      wait_idle("len0_idle");
      chk("len0_no_req", 64'(n_req_cyc - req_snap), 64'd0);

      push_exp(32'hFFFFFFFC, 32'h01234567);
      push_exp(32'h00000000, 32'h89ABCDEF);
      write_frame(32'hFFFFFFFE, 16'd2, {32'h0, 32'h89ABCDEF, 32'h01234567});
      wait_drain("wrap_drain");
      wait_idle("wrap_idle");

      chk("t6_err_cmd_pre", 64'(err_cmd), 64'd0);
`ifdef UART_BOOT_CSUM_EN
      push_exp(32'h60, 32'h01020304);
      send_byte(8'hA5, 1'b1);
      tb_csum = '0;
      put(8'h01);
      put(8'h60); put(8'h00); put(8'h00); put(8'h00);
      put(8'h01); put(8'h00);
      put(8'h04); put(8'h03); put(8'h02); put(8'h01);
      send_byte(~tb_csum, 1'b1);
      wait_drain("csum_drain");
      chk("csum_bad_err", 64'(err_cmd), 64'd1);
`endif
      send_byte(8'hA5, 1'b1);
      send_byte(8'h07, 1'b1);
      chk("t6_err_cmd", 64'(err_cmd), 64'd1);
      push_exp(32'h80, 32'h0BADF00D);
      write_frame(32'h80, 16'd1, {64'h0, 32'h0BADF00D});
      wait_drain("t6_drain");
      wait_idle("t6_idle");

      chk("t4_fetch_pre", 64'(fetch_en), 64'd0);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      chk("t4_fetch", 64'(fetch_en), 64'd1);
      chk("t4_busy", 64'(busy), 64'd0);
      req_snap = n_req_cyc;
      write_frame(32'h500, 16'd1, {64'h0, 32'h12345678});
      repeat (20) @(posedge clk);
      #1;
      chk("t4_no_req", 64'(n_req_cyc - req_snap), 64'd0);
      chk("t4_fetch_sticky", 64'(fetch_en), 64'd1);

      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst2_fetch", 64'(fetch_en), 64'd0);
      chk("rst2_errs", 64'({err_frame, err_ovr, err_cmd}), 64'd0);
      gnt_mode = 2;
      write_frame(32'h10, 16'd1, {64'h0, 32'hFEEDFACE});
      chk("rst3_req_pending", 64'(mem_req), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst3_req_drop", 64'(mem_req), 64'd0);
      rst = 1'b0;
      gnt_mode = 0;
      repeat (20) @(posedge clk);
      #1;
      chk("rst3_busy", 64'(busy), 64'd0);

      chk("no_unexpected_wr", 64'(n_unexp), 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
